// File: rtl/des_feistel_core_if.sv
// Handshake and datapath bundle between the DES round engine, its block source,
// its result consumer and the external key schedule.
interface des_feistel_core_if;
  logic        i_start;
  logic        i_decrypt;
  logic [63:0] i_block;
  logic        o_ready;
  logic [3:0]  o_key_idx;
  logic [47:0] i_subkey;
  logic        o_valid;
  logic        i_out_ready;
  logic [63:0] o_block;

  modport master (
    output i_start, i_decrypt, i_block, i_subkey, i_out_ready,
    input  o_ready, o_key_idx, o_valid, o_block
  );

  modport slave (
    input  i_start, i_decrypt, i_block, i_subkey, i_out_ready,
    output o_ready, o_key_idx, o_valid, o_block
  );
endinterface

// File: rtl/des_feistel_core.sv
// Iterative DES Feistel round engine: one round per clock on a post-IP L/R pair,
// subkeys fetched from an external key schedule addressed by o_key_idx.
//
// state | meaning
// IDLE  | waiting for i_start, o_ready high
// RUN   | one round per edge, counter selects the subkey
// DONE  | result held on o_block with o_valid until consumed
module des_feistel_core #(
  parameter int ROUNDS = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  des_feistel_core_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

  // Row-major (row*16 + col) S-box contents, entry 0 in the top nibble.
  localparam logic [255:0] SBOX_TAB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  logic [1:0]  state;
  logic [31:0] l_q;
  logic [31:0] r_q;
  logic [3:0]  rnd_q;
  logic [3:0]  key_hold_q;
  logic        dec_q;
  logic        valid_q;
  logic [63:0] block_q;

  logic [47:0] e_r;
  logic [47:0] sbox_in;
  logic [31:0] f_pre;
  logic [31:0] f_out;
  logic [31:0] r_next;
  logic [3:0]  key_idx_now;

  // E expansion; DES bit n of R is r_q[32-n].
  assign e_r = {r_q[0], r_q[31:27], r_q[28:23], r_q[24:19], r_q[20:15],
                r_q[16:11], r_q[12:7], r_q[8:3], r_q[4:0], r_q[31]};

  assign sbox_in = e_r ^ bus.i_subkey;

  for (genvar n = 0; n < 8; n++) begin : g_sbox
    logic [5:0] d;
    logic [5:0] idx;
    assign d   = sbox_in[47-6*n -: 6];
    assign idx = {d[5], d[0], d[4:1]};
    assign f_pre[31-4*n -: 4] = SBOX_TAB[n][{~idx, 2'b00} +: 4];
  end

  // P permutation written out as DES bit positions mapped to vector indices.
  assign f_out = {f_pre[16], f_pre[25], f_pre[12], f_pre[11],
                  f_pre[3],  f_pre[20], f_pre[4],  f_pre[15],
                  f_pre[31], f_pre[17], f_pre[9],  f_pre[6],
                  f_pre[27], f_pre[14], f_pre[1],  f_pre[22],
                  f_pre[30], f_pre[24], f_pre[8],  f_pre[18],
                  f_pre[0],  f_pre[5],  f_pre[29], f_pre[23],
                  f_pre[13], f_pre[19], f_pre[2],  f_pre[26],
                  f_pre[10], f_pre[21], f_pre[28], f_pre[7]};

  assign r_next      = l_q ^ f_out;
  assign key_idx_now = dec_q ? (4'd15 - rnd_q) : rnd_q;

  assign bus.o_key_idx = (state == ST_RUN) ? key_idx_now : key_hold_q;
  assign bus.o_ready   = (state == ST_IDLE);
  assign bus.o_valid   = valid_q;
  assign bus.o_block   = block_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      l_q        <= '0;
      r_q        <= '0;
      rnd_q      <= '0;
      key_hold_q <= '0;
      dec_q      <= 1'b0;
      valid_q    <= 1'b0;
      block_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_start) begin
            l_q   <= bus.i_block[63:32];
            r_q   <= bus.i_block[31:0];
            dec_q <= bus.i_decrypt;
            rnd_q <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          l_q        <= r_q;
          r_q        <= r_next;
          rnd_q      <= rnd_q + 4'd1;
          key_hold_q <= key_idx_now;
          // Last round: undo the final swap on the way out.
          if (rnd_q == LAST_RND) begin
            block_q <= {r_next, r_q};
            valid_q <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.i_out_ready) begin
            valid_q <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_feistel_core.sv
// Directed bench for des_feistel_core: a table-driven DES round model plus a
// per-cycle monitor, pinned by published round and ciphertext values.
module tb_des_feistel_core;

  localparam int ROUNDS = 16;

  localparam int E_TAB [48] = '{
    32, 1, 2, 3, 4, 5,   4, 5, 6, 7, 8, 9,   8, 9,10,11,12,13,  12,13,14,15,16,17,
    16,17,18,19,20,21,  20,21,22,23,24,25,  24,25,26,27,28,29,  28,29,30,31,32, 1};

  localparam int P_TAB [32] = '{
    16, 7,20,21,29,12,28,17,  1,15,23,26, 5,18,31,10,
     2, 8,24,14,32,27, 3, 9, 19,13,30, 6,22,11, 4,25};

  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Subkeys K1..K16 for key 133457799BBCDFF1, index 0 = K1.
  localparam logic [47:0] KS [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  logic        clk;
  logic        rst;
  logic        sk_ovr_en;
  logic [47:0] sk_ovr;
  int          n_checks;
  int          n_fail;
  int          cyc;

  des_feistel_core_if bus ();

  des_feistel_core #(.ROUNDS(ROUNDS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  assign bus.i_subkey = sk_ovr_en ? sk_ovr : KS[bus.o_key_idx];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] key_for(input int idx);
    return sk_ovr_en ? sk_ovr : KS[idx];
  endfunction

  function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  c;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_TAB[i]];
    x = x ^ k;
    for (int n = 0; n < 8; n++) begin
      c = x[47-6*n -: 6];
      s[31-4*n -: 4] = 4'(SBOX[n][{c[5], c[0], c[4:1]}]);
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_TAB[i]];
    return p;
  endfunction

  function automatic logic [63:0] des_model(input logic [63:0] blk, input logic dec);
    logic [31:0] l, r, t;
    l = blk[63:32];
    r = blk[31:0];
    for (int k = 0; k < ROUNDS; k++) begin
      t = r;
      r = l ^ f_model(r, key_for(dec ? 15 - k : k));
      l = t;
    end
    return {r, l};
  endfunction

  // Cycle monitor: predicts ready/valid/key index/result from accept time.
  logic        m_busy;
  logic        m_dec;
  logic [63:0] m_exp;
  logic [63:0] m_last;
  int          m_acc;
  int          m_d;

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_last = '0;
    end else if (!m_busy) begin
      check("mon_idle_valid", 64'(bus.o_valid), 64'd0);
      check("mon_idle_ready", 64'(bus.o_ready), 64'd1);
      check("mon_idle_block", bus.o_block, m_last);
      if (bus.i_start) begin
        m_busy = 1'b1;
        m_acc  = cyc + 1;
        m_dec  = bus.i_decrypt;
        m_exp  = des_model(bus.i_block, bus.i_decrypt);
      end
    end else begin
      m_d = cyc - m_acc;
      check("mon_busy_ready", 64'(bus.o_ready), 64'd0);
      if (m_d < ROUNDS) begin
        check("mon_run_valid", 64'(bus.o_valid), 64'd0);
        check("mon_key_idx", 64'(bus.o_key_idx), 64'(m_dec ? 15 - m_d : m_d));
      end else begin
        check("mon_done_valid", 64'(bus.o_valid), 64'd1);
        check("mon_done_block", bus.o_block, m_exp);
        if (bus.i_out_ready) begin
          m_busy = 1'b0;
          m_last = m_exp;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input logic [63:0] blk, input logic dec);
    logic acc;
    int   n;
    bus.i_block   = blk;
    bus.i_decrypt = dec;
    bus.i_start   = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.o_ready;
      tick();
      n++;
    end
    bus.i_start = 1'b0;
    check("start_accepted", 64'(acc), 64'd1);
  endtask

  task automatic wait_valid(input int lat0, output int lat);
    lat = lat0;
    while (!bus.o_valid && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    bus.i_out_ready = 1'b1;
    tick();
    bus.i_out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    int          nv;
    int          prev;
    int          n;
    logic [63:0] hold;
    logic [63:0] exp;

    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst      = 1'b1;
    sk_ovr_en = 1'b0;
    sk_ovr    = '0;
    bus.i_start     = 1'b0;
    bus.i_decrypt   = 1'b0;
    bus.i_block     = '0;
    bus.i_out_ready = 1'b0;

    repeat (2) tick();
    check("rst_ready", 64'(bus.o_ready), 64'd1);
    check("rst_valid", 64'(bus.o_valid), 64'd0);
    check("rst_block", bus.o_block, 64'd0);
    check("rst_key_idx", 64'(bus.o_key_idx), 64'd0);
    rst = 1'b0;

    check("pin_round1", 64'(f_model(32'hF0AAF0AA, KS[0]) ^ 32'hCC00CCFF), 64'hEF4A6544);
    check("pin_encrypt", des_model(64'hCC00CCFF_F0AAF0AA, 1'b0), 64'h0A4CD995_43423234);

    // Grabbe vector, encrypt
    start_block(64'hCC00CCFF_F0AAF0AA, 1'b0);
    check("enc_k1_subkey", 64'(bus.i_subkey), 64'h1B02EFFC7072);
    tick();
    check("enc_r_round1", 64'(dut.r_q), 64'hEF4A6544);
    wait_valid(1, lat);
    check("enc_latency", 64'(lat), 64'(ROUNDS));
    check("enc_block", bus.o_block, 64'h0A4CD995_43423234);
    check("enc_key_hold", 64'(bus.o_key_idx), 64'd15);
    consume();

    // Decrypt: the pre-FP output fed straight back returns the original L0R0
    start_block(64'h0A4CD995_43423234, 1'b1);
    check("dec_first_idx", 64'(bus.o_key_idx), 64'd15);
    wait_valid(0, lat);
    check("dec_latency", 64'(lat), 64'(ROUNDS));
    check("dec_block", bus.o_block, 64'hCC00CCFF_F0AAF0AA);
    check("dec_key_hold", 64'(bus.o_key_idx), 64'd0);
    consume();

    // Backpressure with an ignored start pulse
    start_block(64'h01234567_89ABCDEF, 1'b0);
    wait_valid(0, lat);
    hold = bus.o_block;
    for (int i = 0; i < 10; i++) begin
      bus.i_start = (i == 3);
      tick();
      check("bp_valid", 64'(bus.o_valid), 64'd1);
      check("bp_block", bus.o_block, hold);
      check("bp_ready", 64'(bus.o_ready), 64'd0);
    end
    bus.i_start = 1'b0;
    consume();
    check("bp_release_valid", 64'(bus.o_valid), 64'd0);
    check("bp_release_ready", 64'(bus.o_ready), 64'd1);

    // Asynchronous reset in the middle of round 7
    start_block(64'hFEDCBA98_76543210, 1'b0);
    repeat (7) tick();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(bus.o_valid), 64'd0);
    check("mid_rst_ready", 64'(bus.o_ready), 64'd1);
    check("mid_rst_block", bus.o_block, 64'd0);
    check("mid_rst_key_idx", 64'(bus.o_key_idx), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    exp = des_model(64'h13579BDF_2468ACE0, 1'b0);
    start_block(64'h13579BDF_2468ACE0, 1'b0);
    wait_valid(0, lat);
    check("post_rst_latency", 64'(lat), 64'(ROUNDS));
    check("post_rst_block", bus.o_block, exp);
    consume();

    // Back-to-back: start held, consumer always ready
    bus.i_out_ready = 1'b1;
    bus.i_block     = 64'hA5A5A5A5_5A5A5A5A;
    bus.i_decrypt   = 1'b0;
    bus.i_start     = 1'b1;
    nv = 0;
    prev = -1;
    n = 0;
    while (nv < 3 && n < 120) begin
      tick();
      n++;
      if (bus.o_valid) begin
        if (prev >= 0) check("b2b_spacing", 64'(cyc - prev), 64'(ROUNDS + 2));
        prev = cyc;
        nv++;
        if (nv == 3) bus.i_start = 1'b0;
        tick();
        n++;
        check("b2b_pulse", 64'(bus.o_valid), 64'd0);
      end
    end
    check("b2b_count", 64'(nv), 64'd3);
    bus.i_out_ready = 1'b0;

    // S-box wiring: R = 0, only the S1 chunk of the subkey set to 011000
    sk_ovr_en = 1'b1;
    sk_ovr    = 48'h600000000000;
    start_block(64'h12345678_00000000, 1'b0);
    check("sbox1_nibble", 64'(dut.f_pre[31:28]), 64'h5);
    check("sbox_f_pre", 64'(dut.f_pre), 64'h5FA72C4D);
    check("sbox_f_perm", 64'(dut.f_out), 64'(f_model(32'h0, 48'h600000000000)));
    wait_valid(0, lat);
    check("sbox_latency", 64'(lat), 64'(ROUNDS));
    consume();
    sk_ovr_en = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
